// File: rtl/axi_lite_mem_responder.sv
// AXI4-Lite slave terminating a core master port with a word-addressed memory.
// Ports:
//   ACLK, ARESETN         : clock, async active-low reset
//   S_AXI_AW*/W*/B*       : single-beat write channel with byte strobes
//   S_AXI_AR*/R*          : single-beat read channel
// Responses: OKAY for addr < MEM_WORDS*4, SLVERR otherwise (writes dropped, reads return 0).
module axi_lite_mem_responder #(
  parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_S_AXI_ADDR_WIDTH = 32,
  parameter int unsigned MEM_WORDS          = 256
) (
  input  logic                            ACLK,
  input  logic                            ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY
);

  localparam int unsigned DW    = C_S_AXI_DATA_WIDTH;
  localparam int unsigned AW    = C_S_AXI_ADDR_WIDTH;
  localparam int unsigned SW    = DW / 8;
  localparam int unsigned IDX_W = $clog2(MEM_WORDS);
  localparam logic [AW-1:0] LIMIT = AW'(MEM_WORDS * 4);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {W_IDLE, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  logic [DW-1:0] mem [MEM_WORDS];

  logic             run;
  w_state_t         w_state, w_state_d;
  r_state_t         r_state, r_state_d;
  logic             aw_held, aw_held_d, w_held, w_held_d;
  logic [AW-1:0]    awaddr_q, awaddr_d;
  logic [DW-1:0]    wdata_q, wdata_d;
  logic [SW-1:0]    wstrb_q, wstrb_d;
  logic [1:0]       bresp_q, bresp_d;
  logic [DW-1:0]    rdata_q, rdata_d;
  logic [1:0]       rresp_q, rresp_d;

  logic             aw_fire_c, w_fire_c, ar_fire_c, commit_c;
  logic [AW-1:0]    commit_addr_c;
  logic [DW-1:0]    commit_data_c;
  logic [SW-1:0]    commit_strb_c;

  logic unused_prot;
  assign unused_prot = ^{S_AXI_AWPROT, S_AXI_ARPROT};

  function automatic logic in_range(input logic [AW-1:0] a);
    return a < LIMIT;
  endfunction

  // Handshake outputs are derived from registered state only.
  assign S_AXI_AWREADY = run && (w_state == W_IDLE) && !aw_held;
  assign S_AXI_WREADY  = run && (w_state == W_IDLE) && !w_held;
  assign S_AXI_ARREADY = run && (r_state == R_IDLE);
  assign S_AXI_BVALID  = (w_state == W_RESP);
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_RVALID  = (r_state == R_DATA);
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = rresp_q;

  assign aw_fire_c = S_AXI_AWVALID && S_AXI_AWREADY;
  assign w_fire_c  = S_AXI_WVALID  && S_AXI_WREADY;
  assign ar_fire_c = S_AXI_ARVALID && S_AXI_ARREADY;

  // A held beat takes priority; otherwise the beat on the bus this cycle is used.
  assign commit_addr_c = aw_held ? awaddr_q : S_AXI_AWADDR;
  assign commit_data_c = w_held  ? wdata_q  : S_AXI_WDATA;
  assign commit_strb_c = w_held  ? wstrb_q  : S_AXI_WSTRB;

  // Write FSM next state: capture AW/W independently, commit once both present.
  always_comb begin
    w_state_d = w_state;
    aw_held_d = aw_held;
    w_held_d  = w_held;
    awaddr_d  = awaddr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    bresp_d   = bresp_q;
    commit_c  = 1'b0;
    if (w_state == W_IDLE) begin
      if (aw_fire_c) begin
        aw_held_d = 1'b1;
        awaddr_d  = S_AXI_AWADDR;
      end
      if (w_fire_c) begin
        w_held_d = 1'b1;
        wdata_d  = S_AXI_WDATA;
        wstrb_d  = S_AXI_WSTRB;
      end
      if ((aw_held || aw_fire_c) && (w_held || w_fire_c)) begin
        commit_c  = 1'b1;
        aw_held_d = 1'b0;
        w_held_d  = 1'b0;
        bresp_d   = in_range(commit_addr_c) ? RESP_OKAY : RESP_SLVERR;
        w_state_d = W_RESP;
      end
    end else if (S_AXI_BREADY) begin
      w_state_d = W_IDLE;
    end
  end

  // Read FSM next state: memory sampled before any same-edge write lands.
  always_comb begin
    r_state_d = r_state;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    if (r_state == R_IDLE) begin
      if (ar_fire_c) begin
        r_state_d = R_DATA;
        if (in_range(S_AXI_ARADDR)) begin
          rdata_d = mem[S_AXI_ARADDR[2 +: IDX_W]];
          rresp_d = RESP_OKAY;
        end else begin
          rdata_d = '0;
          rresp_d = RESP_SLVERR;
        end
      end
    end else if (S_AXI_RREADY) begin
      r_state_d = R_IDLE;
    end
  end

  // State and response registers.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      run      <= 1'b0;
      w_state  <= W_IDLE;
      r_state  <= R_IDLE;
      aw_held  <= 1'b0;
      w_held   <= 1'b0;
      awaddr_q <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      bresp_q  <= '0;
      rdata_q  <= '0;
      rresp_q  <= '0;
    end else begin
      run      <= 1'b1;
      w_state  <= w_state_d;
      r_state  <= r_state_d;
      aw_held  <= aw_held_d;
      w_held   <= w_held_d;
      awaddr_q <= awaddr_d;
      wdata_q  <= wdata_d;
      wstrb_q  <= wstrb_d;
      bresp_q  <= bresp_d;
      rdata_q  <= rdata_d;
      rresp_q  <= rresp_d;
    end
  end

  // Memory array: not reset, so contents survive ARESETN.
  always_ff @(posedge ACLK) begin
    if (commit_c && in_range(commit_addr_c)) begin
      for (int unsigned i = 0; i < SW; i++) begin
        if (commit_strb_c[i]) mem[commit_addr_c[2 +: IDX_W]][8*i +: 8] <= commit_data_c[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_axi_lite_mem_responder.sv
// Bench for axi_lite_mem_responder: directed scenarios plus a randomized
// write/read mix compared against a byte-level memory model.
module tb_axi_lite_mem_responder;

  logic        clk, rst_n;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [2:0]  awprot, arprot;
  logic [3:0]  wstrb;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [1:0]  bresp, rresp;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: word contents plus which bytes have ever been written.
  logic [31:0] model [256];
  logic [3:0]  known [256];

  axi_lite_mem_responder #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(32), .MEM_WORDS(256)) dut (
    .ACLK(clk), .ARESETN(rst_n),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [1:0] exp_resp(input logic [31:0] a);
    return (a < 32'd1024) ? 2'b10 ^ 2'b10 : 2'b10;
  endfunction

  function automatic logic [31:0] lane_mask(input logic [3:0] s);
    return {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
  endfunction

  task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] m;
    if (a < 32'd1024) begin
      m = lane_mask(s);
      model[a[9:2]] = (model[a[9:2]] & ~m) | (d & m);
      known[a[9:2]] = known[a[9:2]] | s;
    end
  endtask

  // Drive one write with AW/W launched after independent delays; lat counts extra cycles to BVALID.
  task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int da, input int dw, output logic [1:0] resp, output int lat);
    bit aw_done, w_done, aw_acc, w_acc;
    int cyc;
    aw_done = 0; w_done = 0; cyc = 0;
    awaddr = a; wdata = d; wstrb = s; bready = 1'b1;
    while (!(aw_done && w_done) && cyc < 100) begin
      awvalid = !aw_done && (cyc >= da);
      wvalid  = !w_done && (cyc >= dw);
      aw_acc = awvalid && awready;
      w_acc  = wvalid && wready;
      tick();
      cyc++;
      if (aw_acc) aw_done = 1;
      if (w_acc) w_done = 1;
    end
    awvalid = 1'b0; wvalid = 1'b0;
    lat = 0;
    while (!bvalid && lat < 20) begin tick(); lat++; end
    if (!bvalid) begin
      miscompares++;
      $display("FAIL write_timeout addr=%h", a);
    end
    resp = bresp;
    tick();
    bready = 1'b0;
    model_write(a, d, s);
  endtask

  task automatic axi_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp, output int lat);
    int cyc;
    araddr = a; arvalid = 1'b1; rready = 1'b1; cyc = 0;
    while (!arready && cyc < 50) begin tick(); cyc++; end
    tick();
    arvalid = 1'b0;
    lat = 0;
    while (!rvalid && lat < 20) begin tick(); lat++; end
    if (!rvalid) begin
      miscompares++;
      $display("FAIL read_timeout addr=%h", a);
    end
    d = rdata; resp = rresp;
    tick();
    rready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    awaddr = '0; wdata = '0; wstrb = '0; araddr = '0; awprot = '0; arprot = '0;
    awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0;
    tick(); tick();
    vectors++;
    if ({bvalid, rvalid, bresp, rresp, rdata, awready, wready, arready} !== 41'd0) begin
      miscompares++;
      $display("FAIL reset_outputs got bv=%b rv=%b br=%b rr=%b rd=%h rdy=%b%b%b expected all zero",
               bvalid, rvalid, bresp, rresp, rdata, awready, wready, arready);
    end
    rst_n = 1'b1;
    #3;
    vectors++;
    if ({awready, wready, arready} !== 3'b000) begin
      miscompares++;
      $display("FAIL ready_first_cycle got %b%b%b expected 000", awready, wready, arready);
    end
    tick();
    vectors++;
    if ({awready, wready, arready} !== 3'b111) begin
      miscompares++;
      $display("FAIL ready_after_release got %b%b%b expected 111", awready, wready, arready);
    end
  endtask

  task automatic test_same_cycle_write();
    awaddr = 32'h10; wdata = 32'hDEADBEEF; wstrb = 4'hF; awvalid = 1; wvalid = 1;
    tick();
    awvalid = 0; wvalid = 0;
    model_write(32'h10, 32'hDEADBEEF, 4'hF);
    vectors++;
    if (bvalid !== 1'b1 || bresp !== 2'b00) begin
      miscompares++;
      $display("FAIL aw_w_same_cycle got bvalid=%b bresp=%b expected 1/00", bvalid, bresp);
    end
    bready = 1; tick(); bready = 0;
    araddr = 32'h10; arvalid = 1;
    tick();
    arvalid = 0;
    vectors++;
    if (rvalid !== 1'b1 || rdata !== 32'hDEADBEEF || rresp !== 2'b00) begin
      miscompares++;
      $display("FAIL read_0x10 got rvalid=%b rdata=%h rresp=%b expected 1/deadbeef/00", rvalid, rdata, rresp);
    end
    rready = 1; tick(); rready = 0;
  endtask

  task automatic test_w_first();
    logic [1:0] r; logic [31:0] d; int lat;
    axi_write(32'h14, 32'hFFFFFFFF, 4'hF, 0, 0, r, lat);
    wdata = 32'h11223344; wstrb = 4'h5; wvalid = 1;
    tick();
    wvalid = 0;
    vectors++;
    if (wready !== 1'b0 || bvalid !== 1'b0 || awready !== 1'b1) begin
      miscompares++;
      $display("FAIL w_held got wready=%b bvalid=%b awready=%b expected 0/0/1", wready, bvalid, awready);
    end
    tick(); tick();
    awaddr = 32'h14; awvalid = 1;
    tick();
    awvalid = 0;
    model_write(32'h14, 32'h11223344, 4'h5);
    vectors++;
    if (bvalid !== 1'b1 || bresp !== 2'b00) begin
      miscompares++;
      $display("FAIL aw_late got bvalid=%b bresp=%b expected 1/00", bvalid, bresp);
    end
    bready = 1; tick(); bready = 0;
    axi_read(32'h14, d, r, lat);
    vectors++;
    if (d !== 32'hFF22FF44 || r !== 2'b00) begin
      miscompares++;
      $display("FAIL strobe_merge got %h/%b expected ff22ff44/00", d, r);
    end
  endtask

  task automatic test_backpressure();
    logic [1:0] br0, rr0; logic [31:0] rd0; logic [31:0] nd; bit ok;
    nd = $urandom;
    awaddr = 32'h18; wdata = nd; wstrb = 4'hF; awvalid = 1; wvalid = 1;
    araddr = 32'h10; arvalid = 1;
    tick();
    awvalid = 0; wvalid = 0; arvalid = 0;
    model_write(32'h18, nd, 4'hF);
    br0 = bresp; rr0 = rresp; rd0 = rdata;
    vectors++;
    if (rd0 !== model[4] || rr0 !== 2'b00 || br0 !== 2'b00) begin
      miscompares++;
      $display("FAIL concurrent_rw got rdata=%h rresp=%b bresp=%b expected %h/00/00", rd0, rr0, br0, model[4]);
    end
    ok = 1;
    for (int i = 0; i < 5; i++) begin
      if (bvalid !== 1'b1 || rvalid !== 1'b1 || bresp !== br0 || rresp !== rr0 || rdata !== rd0 ||
          {awready, wready, arready} !== 3'b000) ok = 0;
      tick();
    end
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL hold_stable got bv=%b rv=%b rdy=%b%b%b expected stable valids and readies 000",
               bvalid, rvalid, awready, wready, arready);
    end
    bready = 1; rready = 1;
    tick();
    bready = 0; rready = 0;
    vectors++;
    if ({bvalid, rvalid, awready, wready, arready} !== 5'b00111) begin
      miscompares++;
      $display("FAIL release_ready got %b expected 00111", {bvalid, rvalid, awready, wready, arready});
    end
  endtask

  task automatic test_out_of_range();
    logic [1:0] r; logic [31:0] d; int lat;
    axi_write(32'h0, 32'hC0FFEE01, 4'hF, 0, 0, r, lat);
    axi_write(32'h400, 32'h12345678, 4'hF, 0, 0, r, lat);
    vectors++;
    if (r !== 2'b10) begin
      miscompares++;
      $display("FAIL oor_write_resp got %b expected 10", r);
    end
    axi_read(32'h0, d, r, lat);
    vectors++;
    if (d !== 32'hC0FFEE01 || r !== 2'b00) begin
      miscompares++;
      $display("FAIL oor_no_alias got %h/%b expected c0ffee01/00", d, r);
    end
    axi_read(32'h400, d, r, lat);
    vectors++;
    if (d !== 32'h0 || r !== 2'b10) begin
      miscompares++;
      $display("FAIL oor_read got %h/%b expected 00000000/10", d, r);
    end
    axi_write(32'h3FF, 32'h5A5AA5A5, 4'hF, 0, 0, r, lat);
    axi_read(32'h3FC, d, r, lat);
    vectors++;
    if (d !== 32'h5A5AA5A5 || r !== 2'b00) begin
      miscompares++;
      $display("FAIL last_word got %h/%b expected 5a5aa5a5/00", d, r);
    end
  endtask

  task automatic test_hazard();
    logic [1:0] r; logic [31:0] d; int lat;
    axi_write(32'h20, 32'hAAAA5555, 4'hF, 0, 0, r, lat);
    awaddr = 32'h20; wdata = 32'h12345678; wstrb = 4'hF; awvalid = 1; wvalid = 1;
    araddr = 32'h20; arvalid = 1;
    vectors++;
    if ({awready, wready, arready} !== 3'b111) begin
      miscompares++;
      $display("FAIL hazard_ready got %b%b%b expected 111", awready, wready, arready);
    end
    tick();
    awvalid = 0; wvalid = 0; arvalid = 0;
    vectors++;
    if (rvalid !== 1'b1 || rdata !== 32'hAAAA5555 || bvalid !== 1'b1) begin
      miscompares++;
      $display("FAIL hazard_old got rv=%b rdata=%h bv=%b expected 1/aaaa5555/1", rvalid, rdata, bvalid);
    end
    model_write(32'h20, 32'h12345678, 4'hF);
    bready = 1; rready = 1; tick(); bready = 0; rready = 0;
    axi_read(32'h20, d, r, lat);
    vectors++;
    if (d !== 32'h12345678) begin
      miscompares++;
      $display("FAIL hazard_new got %h expected 12345678", d);
    end
  endtask

  task automatic test_reset_mid();
    logic [1:0] r; logic [31:0] d; int lat;
    awaddr = 32'h24; wdata = 32'h0BADF00D; wstrb = 4'hF; awvalid = 1; wvalid = 1;
    araddr = 32'h10; arvalid = 1;
    tick();
    awvalid = 0; wvalid = 0; arvalid = 0;
    model_write(32'h24, 32'h0BADF00D, 4'hF);
    vectors++;
    if (bvalid !== 1'b1 || rvalid !== 1'b1) begin
      miscompares++;
      $display("FAIL pre_reset got bv=%b rv=%b expected 1/1", bvalid, rvalid);
    end
    #1 rst_n = 1'b0;
    #1;
    vectors++;
    if ({bvalid, rvalid, bresp, rresp, rdata} !== 38'd0) begin
      miscompares++;
      $display("FAIL async_drop got bv=%b rv=%b rdata=%h expected 0/0/0", bvalid, rvalid, rdata);
    end
    tick();
    rst_n = 1'b1;
    #2;
    vectors++;
    if ({awready, wready, arready} !== 3'b000) begin
      miscompares++;
      $display("FAIL mid_release_first got %b%b%b expected 000", awready, wready, arready);
    end
    tick();
    vectors++;
    if ({bvalid, rvalid, awready, wready, arready} !== 5'b00111) begin
      miscompares++;
      $display("FAIL mid_release_idle got %b expected 00111", {bvalid, rvalid, awready, wready, arready});
    end
    axi_read(32'h10, d, r, lat);
    vectors++;
    if (d !== 32'hDEADBEEF) begin
      miscompares++;
      $display("FAIL retained_0x10 got %h expected deadbeef", d);
    end
    axi_read(32'h24, d, r, lat);
    vectors++;
    if (d !== 32'h0BADF00D) begin
      miscompares++;
      $display("FAIL retained_0x24 got %h expected 0badf00d", d);
    end
  endtask

  task automatic test_random();
    logic [31:0] a, d, m, got; logic [3:0] s; logic [1:0] r; int lat;
    for (int n = 0; n < 60; n++) begin
      a = {22'd0, 8'($urandom_range(0, 255)), 2'($urandom)};
      if ($urandom_range(0, 4) == 0) begin
        a = $urandom;
        if (a < 32'd1024) a = a + 32'd1024;
      end
      if ($urandom_range(0, 1) == 1) begin
        d = $urandom; s = 4'($urandom);
        axi_write(a, d, s, $urandom_range(0, 3), $urandom_range(0, 3), r, lat);
        vectors++;
        if (r !== exp_resp(a) || lat != 0) begin
          miscompares++;
          $display("FAIL rand_write a=%h got resp=%b lat=%0d expected %b/0", a, r, lat, exp_resp(a));
        end
      end else begin
        axi_read(a, got, r, lat);
        if (a < 32'd1024) m = lane_mask(known[a[9:2]]);
        else m = 32'hFFFFFFFF;
        d = (a < 32'd1024) ? model[a[9:2]] : 32'h0;
        vectors++;
        if ((got & m) !== (d & m) || r !== exp_resp(a) || lat != 0) begin
          miscompares++;
          $display("FAIL rand_read a=%h got %h/%b lat=%0d expected %h/%b mask=%h", a, got, r, lat, d, exp_resp(a), m);
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      model[i] = '0;
      known[i] = '0;
    end
    test_reset();
    test_same_cycle_write();
    test_w_first();
    test_backpressure();
    test_out_of_range();
    test_hazard();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
